// File: rtl/swu_pkg.sv
// Shared constants and helpers for the sliding-window unit (SWU) line buffer.
// Derived widths, slot count and parameter legality checks used at elaboration.
package swu_pkg;

  function automatic int swu_clog2_min1(input int n);
    int c;
    c = $clog2(n);
    return (c < 1) ? 1 : c;
  endfunction

  function automatic int swu_slots(input int depth, input int mmv);
    return depth / mmv;
  endfunction

  function automatic int swu_addr_w(input int slots);
    return swu_clog2_min1(slots);
  endfunction

  function automatic int swu_cnt_w(input int slots);
    return $clog2(slots + 1);
  endfunction

  function automatic bit swu_px_ok(input int npix, input int ppw);
    return (ppw > 0) && ((npix % ppw) == 0);
  endfunction

  function automatic bit swu_slots_ok(input int slots);
    return slots >= 2;
  endfunction

endpackage

// File: rtl/swu_wr_ctrl_if.sv
// Input stream, credit return and RAM write-port signals of the SWU write controller.
// Widths derive from the buffer geometry so the bus always matches the controller.
interface swu_wr_ctrl_if
  import swu_pkg::*;
#(
  parameter int BUFFER_DEPTH = 20,
  parameter int MMV_IN       = 2
);
  localparam int SLOTS  = swu_slots(BUFFER_DEPTH, MMV_IN);
  localparam int ADDR_W = swu_addr_w(SLOTS);
  localparam int CNT_W  = swu_cnt_w(SLOTS);

  logic              s_valid;
  logic              s_ready;
  logic              restart;
  logic              rd_release;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_last;
  logic              full;
  logic              frame_done;
  logic [CNT_W-1:0]  level;
  logic              err_release;

  modport slave (
    input  s_valid, restart, rd_release,
    output s_ready, wr_en, wr_addr, wr_last, full, frame_done, level, err_release
  );

  modport master (
    output s_valid, restart, rd_release,
    input  s_ready, wr_en, wr_addr, wr_last, full, frame_done, level, err_release
  );

endinterface

// File: rtl/swu_credit_cntr.sv
// Saturating credit counter, resets/clears to MAX; inc+dec together cancel.
// One-edge update; an inc at MAX without dec is dropped and latches err_over.
module swu_credit_cntr #(
  parameter int MAX = 10,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         err_over
);
  localparam logic [W-1:0] CMAX = W'(MAX);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         err_q, err_d;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (clr) begin
      cnt_d = CMAX;
      err_d = 1'b0;
    end else if (inc && !dec) begin
      if (cnt_q == CMAX) err_d = 1'b1;
      else               cnt_d = cnt_q + ONE;
    end else if (dec && !inc) begin
      if (cnt_q != '0) cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cnt_q <= CMAX;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cnt      = cnt_q;
  assign err_over = err_q;

endmodule

// File: rtl/swu_wr_ctrl.sv
// SWU write-side address/credit generator: 0-cycle RAM write in the handshake cycle.
// s_ready drops when no free slot, after frame end, or while restart is high.
module swu_wr_ctrl
  import swu_pkg::*;
#(
  parameter int NPIXELS      = 1024,
  parameter int PX_PER_WORD  = 1,
  parameter int MMV_IN       = 2,
  parameter int BUFFER_DEPTH = 20
) (
  input logic          aclk,
  input logic          aresetn,
  swu_wr_ctrl_if.slave bus
);
  localparam int NWORDS = NPIXELS / PX_PER_WORD;
  localparam int SLOTS  = swu_slots(BUFFER_DEPTH, MMV_IN);
  localparam int ADDR_W = swu_addr_w(SLOTS);
  localparam int CNT_W  = swu_cnt_w(SLOTS);
  localparam int WCNT_W = $clog2(NWORDS + 1);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SLOTS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NWORDS - 1);
  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_SLOTS = CNT_W'(SLOTS);

  if (!swu_px_ok(NPIXELS, PX_PER_WORD)) begin : g_bad_px
    $error("swu_wr_ctrl: NPIXELS must be a multiple of PX_PER_WORD");
  end
  if (!swu_slots_ok(SLOTS)) begin : g_bad_slots
    $error("swu_wr_ctrl: BUFFER_DEPTH/MMV_IN must give at least 2 slots");
  end

  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              full_q, full_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  free_cnt;
  logic              err_over;
  logic              hs;

  assign bus.s_ready = !bus.restart && !done_q && (free_cnt != '0);
  assign hs          = bus.s_valid && bus.s_ready;
  assign bus.wr_en   = hs;
  assign bus.wr_last = hs && (wcnt_q == LAST_WORD);

  always_comb begin
    wr_addr_d = wr_addr_q;
    wcnt_d    = wcnt_q;
    full_d    = full_q;
    done_d    = done_q;
    if (bus.restart) begin
      wr_addr_d = '0;
      wcnt_d    = '0;
      full_d    = 1'b0;
      done_d    = 1'b0;
    end else if (hs) begin
      // Wrapping past the last slot means every slot has been written once.
      if (wr_addr_q == LAST_ADDR) begin
        wr_addr_d = '0;
        full_d    = 1'b1;
      end else begin
        wr_addr_d = wr_addr_q + ADDR_ONE;
      end
      wcnt_d = wcnt_q + WCNT_ONE;
      if (wcnt_q == LAST_WORD) done_d = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_addr_q <= '0;
      wcnt_q    <= '0;
      full_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      wr_addr_q <= wr_addr_d;
      wcnt_q    <= wcnt_d;
      full_q    <= full_d;
      done_q    <= done_d;
    end
  end

  // Counts free slots: a write consumes one, a read-side release returns one.
  swu_credit_cntr #(
    .MAX (SLOTS),
    .W   (CNT_W)
  ) u_credit (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .clr      (bus.restart),
    .inc      (bus.rd_release),
    .dec      (hs),
    .cnt      (free_cnt),
    .err_over (err_over)
  );

  assign bus.wr_addr     = wr_addr_q;
  assign bus.full        = full_q;
  assign bus.frame_done  = done_q;
  assign bus.err_release = err_over;
  assign bus.level       = CNT_SLOTS - free_cnt;

endmodule

// File: tb/tb_swu_wr_ctrl.sv
// Directed bench for swu_wr_ctrl with a 10-slot buffer and a 24-word frame.
module tb_swu_wr_ctrl;
  localparam int NPIXELS      = 24;
  localparam int PX_PER_WORD  = 1;
  localparam int MMV_IN       = 2;
  localparam int BUFFER_DEPTH = 20;
  localparam int SLOTS        = 10;
  localparam int NWORDS       = 24;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  swu_wr_ctrl_if #(.BUFFER_DEPTH(BUFFER_DEPTH), .MMV_IN(MMV_IN)) bus ();

  swu_wr_ctrl #(
    .NPIXELS      (NPIXELS),
    .PX_PER_WORD  (PX_PER_WORD),
    .MMV_IN       (MMV_IN),
    .BUFFER_DEPTH (BUFFER_DEPTH)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    bus.s_valid    = 1'b0;
    bus.restart    = 1'b0;
    bus.rd_release = 1'b0;
    aresetn        = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (bus.wr_addr !== 4'd0) begin n_fail++; $display("FAIL reset_wr_addr: got %0d want 0", bus.wr_addr); end
    n_checks++; if (bus.level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", bus.level); end
    n_checks++; if ({bus.full, bus.frame_done, bus.err_release} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {bus.full, bus.frame_done, bus.err_release}); end
    n_checks++; if (bus.s_ready !== 1'b1 || bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_ready: s_ready=%b wr_en=%b want 1/0", bus.s_ready, bus.wr_en); end
  endtask

  task automatic test_fill();
    int nwr = 0;
    do_reset();
    bus.s_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      #1;
      if (bus.wr_en === 1'b1) begin
        n_checks++; if (bus.wr_addr !== 4'(nwr)) begin n_fail++; $display("FAIL fill_addr: got %0d want %0d", bus.wr_addr, nwr); end
        nwr++;
      end
      tick();
    end
    #1;
    n_checks++; if (nwr != SLOTS) begin n_fail++; $display("FAIL fill_count: got %0d writes want %0d", nwr, SLOTS); end
    n_checks++; if (bus.full !== 1'b1 || bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full: full=%b s_ready=%b want 1/0", bus.full, bus.s_ready); end
    n_checks++; if (bus.level !== 4'd10) begin n_fail++; $display("FAIL fill_level: got %0d want 10", bus.level); end
  endtask

  // Continues from the full buffer left by test_fill.
  task automatic test_steady();
    int  free_m = 0;
    int  exp_addr = 0;
    int  nwr = 0;
    logic exp_rdy;
    bus.s_valid    = 1'b1;
    bus.rd_release = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      exp_rdy = (free_m != 0);
      n_checks++; if (bus.s_ready !== exp_rdy) begin n_fail++; $display("FAIL steady_ready cyc %0d: got %b want %b", i, bus.s_ready, exp_rdy); end
      n_checks++; if (bus.level !== 4'd9 && bus.level !== 4'd10) begin n_fail++; $display("FAIL steady_level cyc %0d: got %0d want 9 or 10", i, bus.level); end
      if (bus.wr_en === 1'b1) begin
        n_checks++; if (bus.wr_addr !== 4'(exp_addr)) begin n_fail++; $display("FAIL steady_addr: got %0d want %0d", bus.wr_addr, exp_addr); end
        exp_addr++;
        nwr++;
      end
      if (!exp_rdy && free_m < SLOTS) free_m++;
      tick();
    end
    bus.rd_release = 1'b0;
    n_checks++; if (nwr != 5) begin n_fail++; $display("FAIL steady_count: got %0d writes want 5", nwr); end
  endtask

  task automatic test_frame_end();
    int nwr = 0;
    do_reset();
    bus.s_valid    = 1'b1;
    bus.rd_release = 1'b1;
    for (int i = 0; i < 30 && nwr < NWORDS; i++) begin
      #1;
      if (bus.wr_en === 1'b1) begin
        n_checks++; if (bus.wr_last !== (nwr == NWORDS - 1)) begin n_fail++; $display("FAIL frame_wr_last word %0d: got %b", nwr, bus.wr_last); end
        if (nwr == NWORDS - 1) begin
          n_checks++; if (bus.wr_addr !== 4'd3) begin n_fail++; $display("FAIL frame_last_addr: got %0d want 3", bus.wr_addr); end
        end
        nwr++;
      end
      tick();
    end
    bus.rd_release = 1'b0;
    #1;
    n_checks++; if (nwr != NWORDS) begin n_fail++; $display("FAIL frame_count: got %0d writes want %0d", nwr, NWORDS); end
    n_checks++; if (bus.frame_done !== 1'b1 || bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL frame_done: frame_done=%b s_ready=%b want 1/0", bus.frame_done, bus.s_ready); end
    n_checks++; if (bus.level !== 4'd0 || bus.full !== 1'b1 || bus.err_release !== 1'b0) begin n_fail++; $display("FAIL frame_state: level=%0d full=%b err=%b want 0/1/0", bus.level, bus.full, bus.err_release); end
  endtask

  task automatic test_restart();
    do_reset();
    bus.s_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #1;
      n_checks++; if (bus.wr_en !== 1'b1) begin n_fail++; $display("FAIL restart_prefill cyc %0d: wr_en=%b want 1", i, bus.wr_en); end
      tick();
    end
    bus.restart = 1'b1;
    #1;
    n_checks++; if (bus.wr_en !== 1'b0 || bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL restart_block: wr_en=%b s_ready=%b want 0/0", bus.wr_en, bus.s_ready); end
    n_checks++; if (bus.level !== 4'd7 || bus.wr_addr !== 4'd7) begin n_fail++; $display("FAIL restart_pre: level=%0d addr=%0d want 7/7", bus.level, bus.wr_addr); end
    tick();
    bus.restart = 1'b0;
    #1;
    n_checks++; if (bus.wr_addr !== 4'd0 || bus.level !== 4'd0 || bus.full !== 1'b0) begin n_fail++; $display("FAIL restart_clear: addr=%0d level=%0d full=%b want 0/0/0", bus.wr_addr, bus.level, bus.full); end
    n_checks++; if (bus.wr_en !== 1'b1) begin n_fail++; $display("FAIL restart_next_write: wr_en=%b want 1", bus.wr_en); end
    tick();
    bus.s_valid = 1'b0;
  endtask

  task automatic test_underflow();
    do_reset();
    bus.rd_release = 1'b1;
    tick();
    bus.rd_release = 1'b0;
    #1;
    n_checks++; if (bus.err_release !== 1'b1 || bus.level !== 4'd0) begin n_fail++; $display("FAIL underflow: err=%b level=%0d want 1/0", bus.err_release, bus.level); end
    tick();
    tick();
    n_checks++; if (bus.err_release !== 1'b1) begin n_fail++; $display("FAIL underflow_sticky: err=%b want 1", bus.err_release); end
  endtask

  // err_release is left set by test_underflow so the reset has to clear it too.
  task automatic test_reset_mid();
    bus.s_valid = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    bus.s_valid = 1'b0;
    #1;
    n_checks++; if (bus.level !== 4'd6 || bus.err_release !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: level=%0d err=%b want 6/1", bus.level, bus.err_release); end
    tick();
    aresetn = 1'b0;
    tick();
    aresetn     = 1'b1;
    bus.s_valid = 1'b1;
    #1;
    n_checks++; if (bus.wr_addr !== 4'd0 || bus.level !== 4'd0) begin n_fail++; $display("FAIL rstmid_regs: addr=%0d level=%0d want 0/0", bus.wr_addr, bus.level); end
    n_checks++; if ({bus.full, bus.frame_done, bus.err_release} !== 3'b000) begin n_fail++; $display("FAIL rstmid_flags: got %b want 000", {bus.full, bus.frame_done, bus.err_release}); end
    n_checks++; if (bus.s_ready !== 1'b1 || bus.wr_en !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: s_ready=%b wr_en=%b want 1/1", bus.s_ready, bus.wr_en); end
    tick();
    bus.s_valid = 1'b0;
  endtask

  initial begin
    bus.s_valid    = 1'b0;
    bus.restart    = 1'b0;
    bus.rd_release = 1'b0;
    test_reset();
    test_fill();
    test_steady();
    test_frame_end();
    test_restart();
    test_underflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
